// File: rtl/mem_wb_skid.sv
// ============================================================================
// mem_wb_skid : MEM/WB stage register with valid/ready and a 2-entry skid
//               buffer. Optional HI/LO payload enabled by MEM_WB_HILO_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_wb_skid #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int LANES  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [LANES*DATA_W-1:0]  mem_wdata,
   input  logic [LANES*ADDR_W-1:0]  mem_waddr,
   input  logic [LANES-1:0]         mem_we,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [LANES*DATA_W-1:0]  wb_wdata,
   output logic [LANES*ADDR_W-1:0]  wb_waddr,
   output logic [LANES-1:0]         wb_we,
`ifdef MEM_WB_HILO_EN
   input  logic [DATA_W-1:0]        mem_hi,
   input  logic [DATA_W-1:0]        mem_lo,
   input  logic                     mem_whilo,
   output logic [DATA_W-1:0]        wb_hi,
   output logic [DATA_W-1:0]        wb_lo,
   output logic                     wb_whilo,
`endif
   output logic [1:0]               occupancy
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   state_e state_q, state_d;
   logic   mem_ready_q, mem_ready_d;
   logic   load_main, load_skid, shift;
   logic   in_fire, out_fire;

   logic [LANES*DATA_W-1:0] main_data_q, skid_data_q;
   logic [LANES*ADDR_W-1:0] main_addr_q, skid_addr_q;
   logic [LANES-1:0]        main_we_q,   skid_we_q;

   assign wb_valid  = (state_q != S_EMPTY);
   assign in_fire   = mem_valid & mem_ready_q;
   assign out_fire  = wb_valid & wb_ready;
   assign mem_ready = mem_ready_q;

   always_comb begin
      state_d   = state_q;
      load_main = 1'b0;
      load_skid = 1'b0;
      shift     = 1'b0;
      case (state_q)
         S_EMPTY: if (in_fire) begin
            load_main = 1'b1;
            state_d   = S_ONE;
         end
         S_ONE: begin
            if (in_fire && out_fire) begin
               load_main = 1'b1;
            end else if (in_fire) begin
               load_skid = 1'b1;
               state_d   = S_TWO;
            end else if (out_fire) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: if (out_fire) begin
            shift   = 1'b1;
            state_d = S_ONE;
         end
         default: state_d = S_EMPTY;
      endcase
      // Flush drops every held entry and any entry arriving this cycle
      if (flush) begin
         state_d   = S_EMPTY;
         load_main = 1'b0;
         load_skid = 1'b0;
         shift     = 1'b0;
      end
      mem_ready_d = (state_d != S_TWO);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_EMPTY;
         mem_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         mem_ready_q <= mem_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         main_data_q <= '0;
         main_addr_q <= '0;
         main_we_q   <= '0;
         skid_data_q <= '0;
         skid_addr_q <= '0;
         skid_we_q   <= '0;
      end else begin
         if (load_main) begin
            main_data_q <= mem_wdata;
            main_addr_q <= mem_waddr;
            main_we_q   <= mem_we;
         end else if (shift) begin
            main_data_q <= skid_data_q;
            main_addr_q <= skid_addr_q;
            main_we_q   <= skid_we_q;
         end
         if (load_skid) begin
            skid_data_q <= mem_wdata;
            skid_addr_q <= mem_waddr;
            skid_we_q   <= mem_we;
         end
      end
   end

   assign wb_wdata  = main_data_q;
   assign wb_waddr  = main_addr_q;
   assign wb_we     = main_we_q & {LANES{wb_valid}};
   assign occupancy = (state_q == S_TWO) ? 2'd2 :
                      (state_q == S_ONE) ? 2'd1 : 2'd0;

`ifdef MEM_WB_HILO_EN
   logic [DATA_W-1:0] main_hi_q, main_lo_q, skid_hi_q, skid_lo_q;
   logic              main_whilo_q, skid_whilo_q;

   // HI/LO outputs read zero after flush, unlike the lane data registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         main_hi_q    <= '0;
         main_lo_q    <= '0;
         main_whilo_q <= 1'b0;
         skid_hi_q    <= '0;
         skid_lo_q    <= '0;
         skid_whilo_q <= 1'b0;
      end else if (flush) begin
         main_hi_q    <= '0;
         main_lo_q    <= '0;
         main_whilo_q <= 1'b0;
      end else begin
         if (load_main) begin
            main_hi_q    <= mem_hi;
            main_lo_q    <= mem_lo;
            main_whilo_q <= mem_whilo;
         end else if (shift) begin
            main_hi_q    <= skid_hi_q;
            main_lo_q    <= skid_lo_q;
            main_whilo_q <= skid_whilo_q;
         end
         if (load_skid) begin
            skid_hi_q    <= mem_hi;
            skid_lo_q    <= mem_lo;
            skid_whilo_q <= mem_whilo;
         end
      end
   end

   assign wb_hi    = main_hi_q;
   assign wb_lo    = main_lo_q;
   assign wb_whilo = main_whilo_q & wb_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_skid.sv
// ============================================================================
// tb_mem_wb_skid : directed + random check of mem_wb_skid against a queue model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_skid;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int L  = 2;

   typedef struct packed {
      logic [L*DW-1:0] d;
      logic [L*AW-1:0] a;
      logic [L-1:0]    we;
      logic [DW-1:0]   hi;
      logic [DW-1:0]   lo;
      logic            whilo;
   } ent_t;

   logic            clk = 1'b0;
   logic            rst, flush, mem_valid, wb_ready;
   logic            mem_ready, wb_valid;
   logic [L*DW-1:0] mem_wdata, wb_wdata;
   logic [L*AW-1:0] mem_waddr, wb_waddr;
   logic [L-1:0]    mem_we, wb_we;
   logic [1:0]      occupancy;
   logic [DW-1:0]   mem_hi, mem_lo;
   logic            mem_whilo;
`ifdef MEM_WB_HILO_EN
   logic [DW-1:0]   wb_hi, wb_lo;
   logic            wb_whilo;
`endif

   int n_chk = 0;
   int n_err = 0;
   ent_t q[$];
   bit   m_ready = 1'b1;

   always #5 clk = ~clk;

   mem_wb_skid #(.DATA_W(DW), .ADDR_W(AW), .LANES(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_wdata (mem_wdata),
      .mem_waddr (mem_waddr),
      .mem_we    (mem_we),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_wdata  (wb_wdata),
      .wb_waddr  (wb_waddr),
      .wb_we     (wb_we),
`ifdef MEM_WB_HILO_EN
      .mem_hi    (mem_hi),
      .mem_lo    (mem_lo),
      .mem_whilo (mem_whilo),
      .wb_hi     (wb_hi),
      .wb_lo     (wb_lo),
      .wb_whilo  (wb_whilo),
`endif
      .occupancy (occupancy)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t mk(input logic [L*DW-1:0] d, input logic [L*AW-1:0] a,
                               input logic [L-1:0] we);
      ent_t e;
      e.d = d; e.a = a; e.we = we; e.hi = '0; e.lo = '0; e.whilo = 1'b0;
      return e;
   endfunction

   function automatic ent_t rnd_ent();
      ent_t e;
      e.d     = {$urandom(), $urandom()};
      e.a     = L*AW'($urandom());
      e.we    = L'($urandom());
      e.hi    = $urandom();
      e.lo    = $urandom();
      e.whilo = 1'($urandom());
      return e;
   endfunction

   // One clock: drive, let the model take the edge, then compare on the falling edge
   task automatic cyc(input bit r, input bit f, input bit v, input bit wr, input ent_t e);
      bit inf, outf;
      rst = r; flush = f; mem_valid = v; wb_ready = wr;
      mem_wdata = e.d; mem_waddr = e.a; mem_we = e.we;
      mem_hi = e.hi; mem_lo = e.lo; mem_whilo = e.whilo;
      @(posedge clk);
      if (!r) begin
         q.delete();
      end else begin
         inf  = v && m_ready;
         outf = (q.size() > 0) && wr;
         if (outf) void'(q.pop_front());
         if (f) q.delete();
         else if (inf) q.push_back(e);
      end
      m_ready = (q.size() < 2);
      @(negedge clk);
      chk("wb_valid", wb_valid, q.size() > 0);
      chk("occupancy", occupancy, q.size());
      chk("mem_ready", mem_ready, m_ready);
      chk("wb_we", wb_we, (q.size() > 0) ? q[0].we : '0);
      if (q.size() > 0) begin
         chk("wb_wdata", wb_wdata, q[0].d);
         chk("wb_waddr", wb_waddr, q[0].a);
`ifdef MEM_WB_HILO_EN
         chk("wb_hi", wb_hi, q[0].hi);
         chk("wb_lo", wb_lo, q[0].lo);
`endif
      end
`ifdef MEM_WB_HILO_EN
      chk("wb_whilo", wb_whilo, (q.size() > 0) ? q[0].whilo : 1'b0);
`endif
   endtask

   initial begin
      ent_t z, e;
      z = mk('0, '0, '0);

      // Reset held two cycles with MEM trying to push
      cyc(0, 0, 1, 1, mk(64'hFFFF_FFFF_FFFF_FFFF, '1, '1));
      cyc(0, 0, 1, 1, mk(64'hFFFF_FFFF_FFFF_FFFF, '1, '1));
      chk("rst_wdata", wb_wdata, 0);
      chk("rst_waddr", wb_waddr, 0);
`ifdef MEM_WB_HILO_EN
      chk("rst_hi", wb_hi, 0);
      chk("rst_lo", wb_lo, 0);
`endif

      // Streaming, one per cycle
      for (int i = 1; i <= 3; i++)
         cyc(1, 0, 1, 1, mk(64'(8'hA0 + i), 10'(i), 2'b01));
      cyc(1, 0, 0, 1, z);

      // Backpressure: 0x11, 0x22 fill, 0x33 held off then drained in order
      cyc(1, 0, 1, 0, mk(64'h11, 10'd1, 2'b01));
      cyc(1, 0, 1, 0, mk(64'h22, 10'd2, 2'b01));
      cyc(1, 0, 1, 0, mk(64'h33, 10'd3, 2'b01));
      cyc(1, 0, 1, 1, mk(64'h33, 10'd3, 2'b01));
      cyc(1, 0, 1, 1, mk(64'h33, 10'd3, 2'b01));
      cyc(1, 0, 0, 1, z);
      cyc(1, 0, 0, 1, z);

      // Flush while full, with a simultaneous push that must vanish
      cyc(1, 0, 1, 0, mk(64'h55, 10'd5, 2'b01));
      cyc(1, 0, 1, 0, mk(64'h66, 10'd6, 2'b01));
      cyc(1, 1, 1, 0, mk(64'h44, 10'd4, 2'b01));
      cyc(1, 0, 0, 1, z);
      cyc(1, 0, 0, 1, z);

      // Two lanes, only lane 0 enabled
      cyc(1, 0, 1, 0, mk({32'hBEEF, 32'hDEAD}, {5'd7, 5'd3}, 2'b01));
      chk("lane_we", wb_we, 2'b01);
      cyc(1, 0, 0, 1, z);
      chk("empty_we", wb_we, 2'b00);

`ifdef MEM_WB_HILO_EN
      e = z; e.hi = 32'h1; e.lo = 32'h2; e.whilo = 1'b1;
      cyc(1, 0, 1, 0, e);
      cyc(1, 0, 0, 0, z);
      cyc(1, 0, 0, 1, z);
      cyc(1, 0, 0, 1, z);
      cyc(1, 1, 0, 1, z);
      chk("flush_hi", wb_hi, 0);
`endif

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 600; i++) begin
         e = rnd_ent();
         cyc(($urandom_range(63) != 0), ($urandom_range(31) == 0),
             ($urandom_range(1) == 0), ($urandom_range(9) < 6), e);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
